mem_write_scheduler: RTL and testbench

MEM_WRITE_SCHEDULER -- requirements
Module: mem_write_scheduler

---
 rtl/mem_write_scheduler_pkg.sv | 21 ++
 rtl/mem_write_scheduler_rr_pick3.sv | 27 ++
 rtl/mem_write_scheduler.sv | 168 ++++++++++++++++
 tb/tb_mem_write_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_write_scheduler_pkg.sv
// Shared definitions for the three-core write scheduler: FSM encodings,
// requester count, parameter defaults and the round-robin index helper.
package mem_write_scheduler_pkg;

    localparam int N_REQ       = 3;
    localparam int DATA_W_DEF  = 2;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // Candidate index 'offset' places after the last winner, wrapping at N_REQ.
    function automatic logic [1:0] rrIndex(input logic [1:0] last, input int offset);
        int s;
        s = int'(last) + 1 + offset;
        return 2'(s % N_REQ);
    endfunction

endpackage

// File: rtl/mem_write_scheduler_rr_pick3.sv
// Combinational round-robin picker for three requesters; the search starts
// one position after the last winner.
module rr_pick3
    import mem_write_scheduler_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    logic [1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rrIndex(last_i, k);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_write_scheduler.sv
// Arbitrates three cores for a single shared memory word (IDLE/GRANT/WRITE/ACK).
// Define ARB_TIMEOUT_EN to abort a grant whose data never arrives.
module mem_write_scheduler
    import mem_write_scheduler_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE_0,
    input  logic              WE_1,
    input  logic              WE_2,
    input  logic [DATA_W-1:0] WD_0,
    input  logic [DATA_W-1:0] WD_1,
    input  logic [DATA_W-1:0] WD_2,
    input  logic              WV_0,
    input  logic              WV_1,
    input  logic              WV_2,
    output logic              WT_0,
    output logic              WT_1,
    output logic              WT_2,
    output logic              DONE_0,
    output logic              DONE_1,
    output logic              DONE_2,
    output logic              ABORT,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WD,
    output logic [1:0]        MEM_SRC
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        win_q, win_d;
    logic [1:0]        last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        src_q, src_d;
    logic              mask_q, mask_d;
    logic [2:0]        wt_q, wt_d;
    logic [2:0]        done_q, done_d;
    logic              memWe_q, memWe_d;
    logic              abort_q, abort_d;

    logic [2:0]        weVec, wvVec, reqMasked;
    logic [DATA_W-1:0] wdSel;
    logic              pickValid;
    logic [1:0]        pickIdx;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign weVec = {WE_2, WE_1, WE_0};
    assign wvVec = {WV_2, WV_1, WV_0};

    // The core served last is hidden for one IDLE cycle so it cannot hog the word.
    assign reqMasked = weVec & ~(mask_q ? (3'b001 << win_q) : 3'b000);

    always_comb begin
        case (win_q)
            2'd1:    wdSel = WD_1;
            2'd2:    wdSel = WD_2;
            default: wdSel = WD_0;
        endcase
    end

    rr_pick3 u_pick (
        .req_i   (reqMasked),
        .last_i  (last_q),
        .valid_o (pickValid),
        .idx_o   (pickIdx)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        data_d  = data_q;
        src_d   = src_q;
        mask_d  = 1'b0;
        abort_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    state_d = ST_GRANT;
                    win_d   = pickIdx;
                    last_d  = pickIdx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                // A data strobe wins over a request that drops in the same cycle.
                if (wvVec[win_q]) begin
                    data_d  = wdSel;
                    src_d   = win_q;
                    state_d = ST_WRITE;
                end else if (!weVec[win_q]) begin
                    state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_WRITE: state_d = ST_ACK;
            ST_ACK: begin
                state_d = ST_IDLE;
                mask_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        wt_d    = (state_d == ST_GRANT || state_d == ST_WRITE) ? (3'b001 << win_d) : 3'b000;
        done_d  = (state_d == ST_ACK) ? (3'b001 << win_d) : 3'b000;
        memWe_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            win_q   <= 2'd0;
            last_q  <= 2'd2;
            data_q  <= '0;
            src_q   <= 2'd0;
            mask_q  <= 1'b0;
            wt_q    <= 3'b000;
            done_q  <= 3'b000;
            memWe_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            data_q  <= data_d;
            src_q   <= src_d;
            mask_q  <= mask_d;
            wt_q    <= wt_d;
            done_q  <= done_d;
            memWe_q <= memWe_d;
            abort_q <= abort_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign ABORT = abort_q;
`else
    assign ABORT = 1'b0;
`endif

    assign {WT_2, WT_1, WT_0}       = wt_q;
    assign {DONE_2, DONE_1, DONE_0} = done_q;
    assign MEM_WE  = memWe_q;
    assign MEM_WD  = data_q;
    assign MEM_SRC = src_q;

endmodule

// File: tb/tb_mem_write_scheduler.sv
// Directed bench for mem_write_scheduler (DATA_W=2, TIMEOUT=4); the
// timeout step adapts to whether ARB_TIMEOUT_EN is defined.
module tb_mem_write_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WE_0, WE_1, WE_2;
    logic [1:0] WD_0, WD_1, WD_2;
    logic       WV_0, WV_1, WV_2;
    logic       WT_0, WT_1, WT_2;
    logic       DONE_0, DONE_1, DONE_2;
    logic       ABORT, MEM_WE;
    logic [1:0] MEM_WD, MEM_SRC;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    mem_write_scheduler #(.DATA_W(2), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .WE_0(WE_0), .WE_1(WE_1), .WE_2(WE_2),
        .WD_0(WD_0), .WD_1(WD_1), .WD_2(WD_2),
        .WV_0(WV_0), .WV_1(WV_1), .WV_2(WV_2),
        .WT_0(WT_0), .WT_1(WT_1), .WT_2(WT_2),
        .DONE_0(DONE_0), .DONE_1(DONE_1), .DONE_2(DONE_2),
        .ABORT(ABORT), .MEM_WE(MEM_WE), .MEM_WD(MEM_WD), .MEM_SRC(MEM_SRC)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] we, input logic [2:0] wv);
        {WE_2, WE_1, WE_0} = we;
        {WV_2, WV_1, WV_0} = wv;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkControl(input string tag, input logic [2:0] wt, input logic [2:0] done,
                                input logic abort, input logic memWe);
        checkOutput({tag, ".wt"},    8'({WT_2, WT_1, WT_0}),       8'(wt));
        checkOutput({tag, ".done"},  8'({DONE_2, DONE_1, DONE_0}), 8'(done));
        checkOutput({tag, ".abort"}, 8'(ABORT),                    8'(abort));
        checkOutput({tag, ".memwe"}, 8'(MEM_WE),                   8'(memWe));
    endtask

    task automatic checkMem(input string tag, input logic [1:0] wd, input logic [1:0] src);
        checkOutput({tag, ".wd"},  8'(MEM_WD),  8'(wd));
        checkOutput({tag, ".src"}, 8'(MEM_SRC), 8'(src));
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(3'b000, 3'b000);
        WD_0 = 2'b00; WD_1 = 2'b00; WD_2 = 2'b00;

        $display("[TB] reset state");
        tick(); tick();
        checkControl("reset", 3'b000, 3'b000, 1'b0, 1'b0);
        checkMem("reset", 2'b00, 2'b00);
        RST = 1'b0;
        tick();
        checkControl("idle", 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] single write from core 1");
        applyStimulus(3'b010, 3'b000);
        tick();
        checkControl("c1.grant", 3'b010, 3'b000, 1'b0, 1'b0);
        WD_1 = 2'b10;
        applyStimulus(3'b010, 3'b010);
        tick();
        checkControl("c1.write", 3'b010, 3'b000, 1'b0, 1'b1);
        checkMem("c1.write", 2'b10, 2'd1);
        applyStimulus(3'b010, 3'b000);
        tick();
        checkControl("c1.ack", 3'b000, 3'b010, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000);
        tick();
        checkControl("c1.idle", 3'b000, 3'b000, 1'b0, 1'b0);
        checkMem("c1.hold", 2'b10, 2'd1);

        $display("[TB] core 2 withdraws during grant");
        applyStimulus(3'b100, 3'b000);
        tick();
        checkControl("c2.grant", 3'b100, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000);
        tick();
        checkControl("c2.drop", 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        checkControl("c2.after", 3'b000, 3'b000, 1'b0, 1'b0);
        checkMem("c2.hold", 2'b10, 2'd1);

        $display("[TB] all cores requesting, rotation 0,1,2,0");
        WD_0 = 2'b01; WD_1 = 2'b10; WD_2 = 2'b11;
        applyStimulus(3'b111, 3'b000);
        tick();
        checkControl("rr0.grant", 3'b001, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b111, 3'b101);
        tick();
        checkControl("rr0.write", 3'b001, 3'b000, 1'b0, 1'b1);
        checkMem("rr0.foreign_wv", 2'b01, 2'd0);
        applyStimulus(3'b111, 3'b000);
        tick();
        checkControl("rr0.ack", 3'b000, 3'b001, 1'b0, 1'b0);
        tick();
        checkControl("rr0.idle", 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        checkControl("rr1.grant", 3'b010, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b111, 3'b010);
        tick();
        checkControl("rr1.write", 3'b010, 3'b000, 1'b0, 1'b1);
        checkMem("rr1.write", 2'b10, 2'd1);
        applyStimulus(3'b111, 3'b000);
        tick();
        checkControl("rr1.ack", 3'b000, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        checkControl("rr2.grant", 3'b100, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b111, 3'b100);
        tick();
        checkControl("rr2.write", 3'b100, 3'b000, 1'b0, 1'b1);
        checkMem("rr2.write", 2'b11, 2'd2);
        applyStimulus(3'b111, 3'b000);
        tick();
        checkControl("rr2.ack", 3'b000, 3'b100, 1'b0, 1'b0);
        tick();
        tick();
        checkControl("rr3.grant", 3'b001, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000);
        tick();
        checkControl("rr3.drop", 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] core 0 granted, data never arrives");
        applyStimulus(3'b001, 3'b000);
        tick();
        checkControl("to.g1", 3'b001, 3'b000, 1'b0, 1'b0);
        tick();
        checkControl("to.g2", 3'b001, 3'b000, 1'b0, 1'b0);
        tick();
        checkControl("to.g3", 3'b001, 3'b000, 1'b0, 1'b0);
        tick();
        checkControl("to.g4", 3'b001, 3'b000, 1'b0, 1'b0);
        tick();
`ifdef ARB_TIMEOUT_EN
        checkControl("to.abort", 3'b000, 3'b000, 1'b1, 1'b0);
`else
        checkControl("to.wait", 3'b001, 3'b000, 1'b0, 1'b0);
`endif
        applyStimulus(3'b000, 3'b000);
        tick();
        checkControl("to.end", 3'b000, 3'b000, 1'b0, 1'b0);

        $display("[TB] reset during WRITE");
        applyStimulus(3'b010, 3'b000);
        tick();
        checkControl("rst.grant", 3'b010, 3'b000, 1'b0, 1'b0);
        WD_1 = 2'b01;
        applyStimulus(3'b010, 3'b010);
        tick();
        checkControl("rst.write", 3'b010, 3'b000, 1'b0, 1'b1);
        checkMem("rst.write", 2'b01, 2'd1);
        #2;
        RST = 1'b1;
        #1;
        checkControl("rst.async", 3'b000, 3'b000, 1'b0, 1'b0);
        checkMem("rst.async", 2'b00, 2'd0);
        tick();
        checkControl("rst.held", 3'b000, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000);
        RST = 1'b0;
        tick();
        checkControl("rst.nodone", 3'b000, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b000);
        tick();
        checkControl("rst.first", 3'b001, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
